// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern-detector run controller.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_TARGET  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/seq_matcher.sv
// History shift register, fill counter and variable-length pattern compare.
module seq_matcher #(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  // Only MAX_LEN-1 past bits are needed; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  assign cand = {hist, bit_in};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
  end

  assign match = shift_en && (fill >= len - LEN_W'(1)) &&
                 (((cand ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= cand[MAX_LEN-2:0];
      if (fill != LEN_W'(MAX_LEN)) fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config latching, session FSM, match and idle-timeout counters.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  parameter  int TO_W    = 16,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_data,
  output logic               bit_ready,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_status,
  input  logic               done_ack
);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [TO_W-1:0]    to_q;
  logic [TO_W-1:0]    to_cnt;
  logic               accept;
  logic               match;
  logic               len_ok;
  logic [CNT_W-1:0]   mc_nxt;
  logic [TO_W-1:0]    to_nxt;
  logic               tgt_hit;
  logic               to_hit;

  assign bit_ready   = (state == RUN);
  assign busy        = (state == ARM) || (state == RUN);
  assign done        = (state == DONE);
  assign accept      = bit_valid && bit_ready;
  assign match_pulse = match;
  assign len_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  seq_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == ARM),
    .shift_en (accept),
    .bit_in   (bit_data),
    .pattern  (pat_q),
    .len      (len_q),
    .match    (match)
  );

  // Next-count values; termination is judged on these so a match on the
  // terminating cycle is both counted and able to hit the target.
  always_comb begin
    mc_nxt = match_count;
    if (match && (match_count != '1)) mc_nxt = match_count + CNT_W'(1);
    to_nxt  = match ? '0 : to_cnt + TO_W'(1);
    tgt_hit = (tgt_q != '0) && (mc_nxt >= tgt_q);
    to_hit  = (to_q != '0) && (to_nxt == to_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      tgt_q       <= '0;
      to_q        <= '0;
      to_cnt      <= '0;
      match_count <= '0;
      done_status <= ST_NONE;
    end else begin
      case (state)
        IDLE: if (start) begin
          pat_q       <= cfg_pattern;
          len_q       <= len_ok ? cfg_len : LEN_W'(1);
          tgt_q       <= cfg_target;
          to_q        <= cfg_timeout;
          match_count <= '0;
          done_status <= ST_NONE;
          state       <= ARM;
        end
        ARM: begin
          to_cnt <= '0;
          if (abort) begin
            done_status <= ST_ABORT;
            state       <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          to_cnt      <= to_nxt;
          match_count <= mc_nxt;
          if (abort) begin
            done_status <= ST_ABORT;
            state       <= DONE;
          end else if (tgt_hit) begin
            done_status <= ST_TARGET;
            state       <= DONE;
          end else if (to_hit) begin
            done_status <= ST_TIMEOUT;
            state       <= DONE;
          end
        end
        DONE: if (done_ack) begin
          done_status <= ST_NONE;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with hand-computed expectations.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic [TO_W-1:0]    cfg_timeout = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               bit_valid = 1'b0;
  logic               bit_data = 1'b0;
  logic               done_ack = 1'b0;
  logic               bit_ready;
  logic               match_pulse;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  logic [1:0]         done_status;

  int n_tests = 0;
  int n_fail  = 0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .done_status (done_status),
    .done_ack    (done_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start with a config, then step through ARM into RUN.
  task automatic do_start(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] t, input logic [TO_W-1:0] to);
    cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = to;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send(input logic b, input logic exp_m, input string tag);
    bit_valid = 1'b1;
    bit_data  = b;
    @(negedge clk);
    chk(tag, match_pulse, exp_m);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic end_session(input logic [1:0] exp_st, input string tag);
    if (!done) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk({tag, "_status"}, done_status, exp_st);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk({tag, "_idle"}, {busy, done, done_status}, 4'b0);
  endtask

  initial begin
    #3;
    chk("rst_outputs", {bit_ready, match_pulse, match_count, busy, done, done_status}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Overlapping matches of 0110.
    do_start(8'b0110, 4, 0, 0);
    chk("t1_busy_ready", {busy, bit_ready}, 2'b11);
    send(0, 0, "t1_b1"); send(1, 0, "t1_b2"); send(1, 0, "t1_b3"); send(0, 1, "t1_b4");
    send(1, 0, "t1_b5"); send(1, 0, "t1_b6"); send(0, 1, "t1_b7");
    chk("t1_count", match_count, 2);
    end_session(2'b11, "t1");
    chk("t1_count_hold", match_count, 2);

    // Target of 2 on pattern 101.
    do_start(8'b101, 3, 2, 0);
    send(1, 0, "t2_b1"); send(0, 0, "t2_b2"); send(1, 1, "t2_b3");
    send(0, 0, "t2_b4");
    chk("t2_not_done", done, 0);
    send(1, 1, "t2_b5");
    chk("t2_done", {done, done_status, match_count}, {1'b1, 2'b01, 8'd2});
    bit_valid = 1'b1; bit_data = 1'b1;
    @(negedge clk);
    chk("t2_no_ready", {bit_ready, match_pulse}, 2'b00);
    tick();
    bit_valid = 1'b0;
    chk("t2_count_hold", match_count, 2);
    end_session(2'b01, "t2");

    // Idle timeout of 5 with no bits.
    do_start(8'b0110, 4, 0, 5);
    repeat (4) tick();
    chk("t3_before_to", done, 0);
    tick();
    chk("t3_timeout", {done, done_status}, 3'b110);
    end_session(2'b10, "t3");

    // Abort in ARM.
    cfg_pattern = 8'b0110; cfg_len = 4; cfg_target = 0; cfg_timeout = 0;
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4a_abort_arm", {busy, done, done_status}, 4'b0111);
    end_session(2'b11, "t4a");

    // Abort mid-RUN on a matching accepted bit.
    do_start(8'b0110, 4, 0, 0);
    send(0, 0, "t4b_b1"); send(1, 0, "t4b_b2"); send(1, 0, "t4b_b3");
    abort = 1'b1;
    send(0, 1, "t4b_b4");
    abort = 1'b0;
    chk("t4b_abort_run", {done, done_status, match_count}, {1'b1, 2'b11, 8'd1});
    end_session(2'b11, "t4b");

    // Async reset mid-RUN, then a clean session.
    do_start(8'b0110, 4, 0, 0);
    send(0, 0, "t5_b1"); send(1, 0, "t5_b2"); send(1, 0, "t5_b3");
    bit_valid = 1'b1; bit_data = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", {bit_ready, match_pulse, match_count, busy, done, done_status}, '0);
    bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
    do_start(8'b0110, 4, 0, 0);
    send(0, 0, "t5_r1"); send(1, 0, "t5_r2"); send(1, 0, "t5_r3"); send(0, 1, "t5_r4");
    end_session(2'b11, "t5");

    // Illegal length 0 latched as 1.
    do_start(8'b1, 0, 0, 0);
    send(0, 0, "t6_b1"); send(1, 1, "t6_b2"); send(1, 1, "t6_b3");
    chk("t6_count", match_count, 2);
    end_session(2'b11, "t6");

    // Config change during RUN; start with done_ack in DONE.
    do_start(8'b0110, 4, 1, 0);
    cfg_pattern = 8'b1001; cfg_len = 2;
    send(0, 0, "t7_b1"); send(1, 0, "t7_b2"); send(1, 0, "t7_b3"); send(0, 1, "t7_b4");
    chk("t7_done", {done, done_status, match_count}, {1'b1, 2'b01, 8'd1});
    start = 1'b1; done_ack = 1'b1;
    tick();
    start = 1'b0; done_ack = 1'b0;
    chk("t7_to_idle", {busy, done}, 2'b00);
    tick();
    chk("t7_no_rearm", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
